// File: rtl/hbm_sched_pkg.sv
// hbm_sched_pkg: shared constants for the HBM read scheduler.
//   - dispatcher FSM state encoding
//   - default config setup latency
//   - descriptor field widths that are fixed (burst size, perf counter)
package hbm_sched_pkg;

  // Dispatcher FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;

  // Engines register config twice before using it, so config must be
  // stable this many cycles before the start pulse.
  localparam int SETUP_CYCLES_DEF = 2;

  // Descriptor burst-size field width (bytes)
  localparam int BURST_W = 16;

  // Per-engine performance counter width
  localparam int PERF_W = 32;

endpackage

// File: rtl/hbm_sched_engine_slot.sv
// hbm_sched_engine_slot: per-engine state for the HBM read scheduler.
// Holds the engine's configuration from latch until completion, tracks
// busy, counts returned RLAST beats and flags completion combinationally.
//
// Optional macro HBM_SCHED_PERF_EN adds a busy-cycle counter per engine.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   latch             capture cfg_* and claim the engine (one cycle)
//   cfg_addr/stride/ops/burst  descriptor fields to capture
//   rlast             RVALID&RLAST seen from this engine
//   start             (perf only) start pulse, clears perf counter
//   perf              (perf only) busy cycles since last start, saturating
//   init_addr/stride/read_ops/burst_size  held config towards the engine
//   busy              engine owns an in-flight descriptor
//   done              final RLAST of the operation this cycle
module hbm_sched_engine_slot
  import hbm_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 33,
  parameter int OPS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  latch,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [OPS_WIDTH-1:0]  cfg_stride,
  input  logic [OPS_WIDTH-1:0]  cfg_ops,
  input  logic [BURST_W-1:0]    cfg_burst,
  input  logic                  rlast,
`ifdef HBM_SCHED_PERF_EN
  input  logic                  start,
  output logic [PERF_W-1:0]     perf,
`endif
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic [OPS_WIDTH-1:0]  stride,
  output logic [OPS_WIDTH-1:0]  read_ops,
  output logic [BURST_W-1:0]    burst_size,
  output logic                  busy,
  output logic                  done
);

  logic [OPS_WIDTH-1:0] rlast_cnt;
  logic [OPS_WIDTH-1:0] cnt_nxt;

  // Completion includes the beat arriving this cycle so done fires on the
  // final RLAST itself rather than one cycle later.
  assign cnt_nxt = rlast_cnt + OPS_WIDTH'(rlast);
  assign done    = busy && (cnt_nxt == read_ops);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_addr  <= '0;
      stride     <= '0;
      read_ops   <= '0;
      burst_size <= '0;
      busy       <= 1'b0;
      rlast_cnt  <= '0;
    end else if (latch) begin
      init_addr  <= cfg_addr;
      stride     <= cfg_stride;
      read_ops   <= cfg_ops;
      burst_size <= cfg_burst;
      busy       <= 1'b1;
      rlast_cnt  <= '0;
    end else if (busy) begin
      // Stray beats on an idle engine are ignored by the busy guard.
      if (rlast) rlast_cnt <= cnt_nxt;
      if (done)  busy      <= 1'b0;
    end
  end

`ifdef HBM_SCHED_PERF_EN
  // Counts every busy cycle after start, including the done cycle, then
  // holds once busy drops until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      perf <= '0;
    else if (start)                  perf <= '0;
    else if (busy && (perf != '1))   perf <= perf + 1'b1;
  end
`endif

endmodule

// File: rtl/hbm_read_scheduler.sv
// hbm_read_scheduler: dispatches read descriptors from a valid/ready
// queue onto NUM_ENGINES HBM read engines. An idle engine is chosen
// round-robin, its config is latched and held, setup cycles elapse, a
// single start pulse is issued, and completion is detected by counting
// RLAST beats against the op count.
//
// Optional macro HBM_SCHED_PERF_EN adds perf_cycles (32 bits per engine).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   desc_valid/ready      descriptor handshake
//   desc_addr/stride/ops/burst  descriptor fields
//   eng_start             one-cycle start pulse per engine
//   eng_init_addr/stride/read_ops/burst_size  per-engine config, slice i
//   eng_rlast             RVALID&RLAST per engine
//   eng_busy              engine owns an in-flight descriptor
//   done_vec              one-cycle completion pulse per engine
//   all_idle              nothing busy and dispatcher idle
//   perf_cycles           (perf only) per-engine busy cycle counts
module hbm_read_scheduler
  import hbm_sched_pkg::*;
#(
  parameter int NUM_ENGINES  = 4,
  parameter int ADDR_WIDTH   = 33,
  parameter int OPS_WIDTH    = 32,
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              desc_valid,
  output logic                              desc_ready,
  input  logic [ADDR_WIDTH-1:0]             desc_addr,
  input  logic [OPS_WIDTH-1:0]              desc_stride,
  input  logic [OPS_WIDTH-1:0]              desc_ops,
  input  logic [BURST_W-1:0]                desc_burst,
  output logic [NUM_ENGINES-1:0]            eng_start,
  output logic [NUM_ENGINES*ADDR_WIDTH-1:0] eng_init_addr,
  output logic [NUM_ENGINES*OPS_WIDTH-1:0]  eng_stride,
  output logic [NUM_ENGINES*OPS_WIDTH-1:0]  eng_read_ops,
  output logic [NUM_ENGINES*BURST_W-1:0]    eng_burst_size,
  input  logic [NUM_ENGINES-1:0]            eng_rlast,
  output logic [NUM_ENGINES-1:0]            eng_busy,
  output logic [NUM_ENGINES-1:0]            done_vec,
`ifdef HBM_SCHED_PERF_EN
  output logic [NUM_ENGINES*PERF_W-1:0]     perf_cycles,
`endif
  output logic                              all_idle
);

  localparam int IDXW = $clog2(NUM_ENGINES);
  localparam int SCW  = $clog2(SETUP_CYCLES + 1);

  logic [1:0]             state;
  logic [SCW-1:0]         setup_cnt;
  logic [IDXW-1:0]        rr;
  logic [IDXW-1:0]        cur;
  logic [IDXW-1:0]        pick;
  logic                   any_free;
  logic                   armed;
  logic                   hs;
  logic                   ops_nz;
  logic [NUM_ENGINES-1:0] latch;
  logic [NUM_ENGINES-1:0] slot_done;
  logic [NUM_ENGINES-1:0] zero_done;
  int                     scan_idx;

  // Round-robin picker: first non-busy engine at or after rr, wrapping.
  always_comb begin
    pick     = '0;
    any_free = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      scan_idx = int'(rr) + k;
      if (scan_idx >= NUM_ENGINES) scan_idx = scan_idx - NUM_ENGINES;
      if (!any_free && !eng_busy[IDXW'(scan_idx)]) begin
        pick     = IDXW'(scan_idx);
        any_free = 1'b1;
      end
    end
  end

  // armed keeps desc_ready low while in reset and for the first edge out.
  assign desc_ready = armed && (state == ST_IDLE) && any_free;
  assign hs         = desc_valid && desc_ready;
  assign ops_nz     = (desc_ops != '0);
  assign done_vec   = slot_done | zero_done;
  assign all_idle   = (state == ST_IDLE) && (eng_busy == '0) && !hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      setup_cnt <= '0;
      rr        <= '0;
      cur       <= '0;
      armed     <= 1'b0;
      zero_done <= '0;
    end else begin
      armed     <= 1'b1;
      zero_done <= '0;
      case (state)
        ST_IDLE: if (hs) begin
          rr <= (pick == IDXW'(NUM_ENGINES - 1)) ? '0 : pick + 1'b1;
          if (ops_nz) begin
            cur       <= pick;
            setup_cnt <= '0;
            state     <= ST_SETUP;
          end else begin
            // A zero-op engine would never see RLAST; report done directly.
            zero_done <= NUM_ENGINES'(1) << pick;
          end
        end
        ST_SETUP: begin
          setup_cnt <= setup_cnt + 1'b1;
          if (setup_cnt == SCW'(SETUP_CYCLES - 1)) state <= ST_START;
        end
        ST_START: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_slot
    assign latch[g]     = hs && ops_nz && (pick == IDXW'(g));
    assign eng_start[g] = (state == ST_START) && (cur == IDXW'(g));

    hbm_sched_engine_slot #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .OPS_WIDTH  (OPS_WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .latch      (latch[g]),
      .cfg_addr   (desc_addr),
      .cfg_stride (desc_stride),
      .cfg_ops    (desc_ops),
      .cfg_burst  (desc_burst),
      .rlast      (eng_rlast[g]),
`ifdef HBM_SCHED_PERF_EN
      .start      (eng_start[g]),
      .perf       (perf_cycles[g*PERF_W +: PERF_W]),
`endif
      .init_addr  (eng_init_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .stride     (eng_stride[g*OPS_WIDTH +: OPS_WIDTH]),
      .read_ops   (eng_read_ops[g*OPS_WIDTH +: OPS_WIDTH]),
      .burst_size (eng_burst_size[g*BURST_W +: BURST_W]),
      .busy       (eng_busy[g]),
      .done       (slot_done[g])
    );
  end

endmodule

// File: tb/tb_hbm_read_scheduler.sv
// Self-checking bench for hbm_read_scheduler. Expected dispatches are
// queued when a descriptor is accepted and checked when eng_start fires.
module tb_hbm_read_scheduler;
  localparam int N  = 4;
  localparam int AW = 33;
  localparam int OW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            desc_valid = 1'b0;
  logic            desc_ready;
  logic [AW-1:0]   desc_addr = '0;
  logic [OW-1:0]   desc_stride = '0;
  logic [OW-1:0]   desc_ops = '0;
  logic [15:0]     desc_burst = '0;
  logic [N-1:0]    eng_start;
  logic [N*AW-1:0] eng_init_addr;
  logic [N*OW-1:0] eng_stride;
  logic [N*OW-1:0] eng_read_ops;
  logic [N*16-1:0] eng_burst_size;
  logic [N-1:0]    eng_rlast = '0;
  logic [N-1:0]    eng_busy;
  logic [N-1:0]    done_vec;
  logic            all_idle;
`ifdef HBM_SCHED_PERF_EN
  logic [N*32-1:0] perf_cycles;
`endif

  hbm_read_scheduler #(.NUM_ENGINES(N), .ADDR_WIDTH(AW), .OPS_WIDTH(OW), .SETUP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_stride(desc_stride), .desc_ops(desc_ops), .desc_burst(desc_burst),
    .eng_start(eng_start), .eng_init_addr(eng_init_addr), .eng_stride(eng_stride),
    .eng_read_ops(eng_read_ops), .eng_burst_size(eng_burst_size), .eng_rlast(eng_rlast),
    .eng_busy(eng_busy), .done_vec(done_vec),
`ifdef HBM_SCHED_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .all_idle(all_idle));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            eng;
    logic [AW-1:0] a;
    logic [OW-1:0] s;
    logic [OW-1:0] o;
    logic [15:0]   b;
    int            cyc;
  } exp_t;
  exp_t sq[$];

  // Scoreboard: every start pulse must match the oldest accepted descriptor
  // in engine, timing (3 cycles after handshake) and held config.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && eng_start !== '0) begin
      for (int i = 0; i < N; i++) begin
        if (eng_start[i]) begin
          checks++;
          if (sq.size() == 0) begin
            errors++;
            $display("FAIL start_unexpected eng=%0d cyc=%0d required no start", i, cyc);
          end else begin
            e = sq.pop_front();
            if (e.eng != i || e.cyc != cyc || eng_init_addr[i*AW +: AW] !== e.a ||
                eng_stride[i*OW +: OW] !== e.s || eng_read_ops[i*OW +: OW] !== e.o ||
                eng_burst_size[i*16 +: 16] !== e.b) begin
              errors++;
              $display("FAIL start_match got eng=%0d cyc=%0d addr=%h stride=%h ops=%0d burst=%0d required eng=%0d cyc=%0d addr=%h stride=%h ops=%0d burst=%0d",
                       i, cyc, eng_init_addr[i*AW +: AW], eng_stride[i*OW +: OW],
                       eng_read_ops[i*OW +: OW], eng_burst_size[i*16 +: 16],
                       e.eng, e.cyc, e.a, e.s, e.o, e.b);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive rlast mask and stop at the negedge of that cycle for checking.
  task automatic rl(input logic [N-1:0] m);
    eng_rlast = m;
    @(negedge clk);
  endtask

  task automatic do_reset();
    eng_rlast = '0; desc_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL pending_starts got=%0d required 0", sq.size());
    end
    sq.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after handshake.
  task automatic send(input logic [AW-1:0] a, input logic [OW-1:0] s, input logic [OW-1:0] o,
                      input logic [15:0] b, input int exp_eng);
    int   n;
    exp_t e;
    n = 0;
    desc_valid = 1'b1; desc_addr = a; desc_stride = s; desc_ops = o; desc_burst = b;
    @(negedge clk);
    while (desc_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout ready=%b required 1", desc_ready);
    end else if (o != 0) begin
      e.eng = exp_eng; e.a = a; e.s = s; e.o = o; e.b = b; e.cyc = cyc + 3;
      sq.push_back(e);
    end
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b0 || eng_start !== '0 || eng_busy !== '0 || done_vec !== '0 ||
        all_idle !== 1'b1 || eng_init_addr !== '0 || eng_stride !== '0 ||
        eng_read_ops !== '0 || eng_burst_size !== '0) begin
      errors++;
      $display("FAIL reset_values ready=%b start=%b busy=%b done=%b idle=%b required 0 0 0 0 1 with zero config",
               desc_ready, eng_start, eng_busy, done_vec, all_idle);
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    send(33'h1000, 32'h200, 4, 128, 0);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (eng_busy !== 4'b0001 || desc_ready !== 1'b1 || all_idle !== 1'b0) begin
      errors++;
      $display("FAIL single_busy busy=%b ready=%b idle=%b required 0001 1 0", eng_busy, desc_ready, all_idle);
    end
    tick();
    for (int k = 1; k <= 4; k++) begin
      rl(4'b0001);
      checks++;
      if (done_vec !== ((k == 4) ? 4'b0001 : 4'b0000) || eng_busy !== 4'b0001) begin
        errors++;
        $display("FAIL single_beat%0d done=%b busy=%b required %b 0001", k, done_vec, eng_busy,
                 (k == 4) ? 4'b0001 : 4'b0000);
      end
      tick();
      eng_rlast = '0;
      if (k < 4) tick();
    end
    @(negedge clk);
    checks++;
    if (eng_busy !== 4'b0000 || done_vec !== 4'b0000 || all_idle !== 1'b1 ||
        eng_init_addr[AW-1:0] !== 33'h1000 || eng_read_ops[OW-1:0] !== 32'd4) begin
      errors++;
      $display("FAIL single_after busy=%b done=%b idle=%b addr=%h ops=%0d required 0000 0000 1 1000 4",
               eng_busy, done_vec, all_idle, eng_init_addr[AW-1:0], eng_read_ops[OW-1:0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++)
      send(33'h10000 + 33'(k * 'h100), 32'h40 + 32'(k), (k == 2) ? 1 : 3, 16'(64 * (k + 1)), k);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (eng_busy !== 4'b1111 || desc_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full busy=%b ready=%b required 1111 0", eng_busy, desc_ready);
    end
    tick();
    fork
      send(33'h50000, 32'h80, 2, 256, 2);
      begin
        tick(); tick();
        rl(4'b0100);
        checks++;
        if (done_vec !== 4'b0100 || desc_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_free done=%b ready=%b required 0100 0", done_vec, desc_ready);
        end
        tick();
        eng_rlast = '0;
      end
    join
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (eng_busy !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_reclaim busy=%b required 1111", eng_busy);
    end
    tick();
  endtask

  task automatic test_zero_ops();
    do_reset();
    send(33'h2000, 32'h40, 0, 64, 0);
    @(negedge clk);
    checks++;
    if (done_vec !== 4'b0001 || eng_busy !== 4'b0000 || eng_start !== 4'b0000 || all_idle !== 1'b1) begin
      errors++;
      $display("FAIL zero_done done=%b busy=%b start=%b idle=%b required 0001 0000 0000 1",
               done_vec, eng_busy, eng_start, all_idle);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done_vec !== 4'b0000) begin
      errors++;
      $display("FAIL zero_pulse_len done=%b required 0000", done_vec);
    end
    tick();
    send(33'h3000, 32'h40, 1, 64, 1);
    repeat (3) tick();
    rl(4'b0010);
    checks++;
    if (done_vec !== 4'b0010) begin
      errors++;
      $display("FAIL zero_next done=%b required 0010", done_vec);
    end
    tick();
    eng_rlast = '0;
  endtask

  task automatic test_simul_done();
    exp_t e;
    do_reset();
    for (int k = 0; k < 4; k++) send(33'h6000 + 33'(k * 'h10), 32'h20, 1, 32, k);
    repeat (3) tick();
    eng_rlast = 4'b1010;
    desc_valid = 1'b1; desc_addr = 33'h7000; desc_stride = 32'h30; desc_ops = 1; desc_burst = 96;
    @(negedge clk);
    checks++;
    if (done_vec !== 4'b1010 || desc_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_done done=%b ready=%b required 1010 0", done_vec, desc_ready);
    end
    tick();
    eng_rlast = '0;
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_ready ready=%b required 1", desc_ready);
    end else begin
      e.eng = 1; e.a = 33'h7000; e.s = 32'h30; e.o = 1; e.b = 96; e.cyc = cyc + 3;
      sq.push_back(e);
    end
    tick();
    desc_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (eng_busy !== 4'b0111) begin
      errors++;
      $display("FAIL simul_busy busy=%b required 0111", eng_busy);
    end
    tick();
    rl(4'b1000);
    checks++;
    if (done_vec !== 4'b0000 || eng_busy !== 4'b0111) begin
      errors++;
      $display("FAIL stray_rlast done=%b busy=%b required 0000 0111", done_vec, eng_busy);
    end
    tick();
    rl(4'b0111);
    checks++;
    if (done_vec !== 4'b0111) begin
      errors++;
      $display("FAIL triple_done done=%b required 0111", done_vec);
    end
    tick();
    eng_rlast = '0;
    @(negedge clk);
    checks++;
    if (eng_busy !== 4'b0000 || all_idle !== 1'b1) begin
      errors++;
      $display("FAIL triple_idle busy=%b idle=%b required 0000 1", eng_busy, all_idle);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(33'h8000, 32'h100, 8, 256, 0);
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      rl(4'b0001);
      checks++;
      if (done_vec !== 4'b0000) begin
        errors++;
        $display("FAIL mid_beat%0d done=%b required 0000", k, done_vec);
      end
      tick();
      eng_rlast = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (eng_busy !== '0 || done_vec !== '0 || eng_start !== '0 || desc_ready !== 1'b0 ||
        all_idle !== 1'b1 || eng_init_addr !== '0 || eng_read_ops !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b start=%b ready=%b idle=%b required 0 0 0 0 1 with zero config",
               eng_busy, done_vec, eng_start, desc_ready, all_idle);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 6; k++) begin
      rl(4'b0001);
      checks++;
      if (done_vec !== 4'b0000 || eng_busy !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset_rlast%0d done=%b busy=%b required 0000 0000", k, done_vec, eng_busy);
      end
      tick();
      eng_rlast = '0;
    end
  endtask

`ifdef HBM_SCHED_PERF_EN
  task automatic test_perf();
    int          n;
    logic [31:0] p0;
    do_reset();
    send(33'hA000, 32'h80, 2, 128, 0);
    n = 0;
    @(negedge clk);
    while (eng_start[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (eng_start[0] !== 1'b1) begin
      errors++;
      $display("FAIL perf_start_timeout start=%b required 1", eng_start[0]);
    end
    repeat (10) @(posedge clk);
    #1 eng_rlast = 4'b0001;
    @(posedge clk); #1 eng_rlast = '0;
    repeat (9) @(posedge clk);
    #1 eng_rlast = 4'b0001;
    @(negedge clk);
    checks++;
    if (done_vec !== 4'b0001) begin
      errors++;
      $display("FAIL perf_done done=%b required 0001", done_vec);
    end
    tick();
    eng_rlast = '0;
    repeat (3) tick();
    @(negedge clk);
    p0 = perf_cycles[31:0];
    checks++;
    if (p0 < 19 || p0 > 21) begin
      errors++;
      $display("FAIL perf_value got=%0d required 20 +/- 1", p0);
    end
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if (perf_cycles[31:0] !== p0) begin
      errors++;
      $display("FAIL perf_hold got=%0d required %0d", perf_cycles[31:0], p0);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_ops();
    test_simul_done();
    test_reset_mid();
`ifdef HBM_SCHED_PERF_EN
    test_perf();
`endif
    repeat (4) tick();
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL final_pending got=%0d required 0", sq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
